// File: rtl/key_repeat.sv
// Converts a debounced key level into one-cycle press/release/auto-repeat strobes,
// with a long-press level and a wrapping count of accepted presses.
module key_repeat #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32,
  parameter logic        ACTIVE_LVL    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       key_in,
  output logic       press,
  // Release strobe; named key_release because "release" is a reserved word.
  output logic       key_release,
  output logic       rpt,
  output logic       step,
  output logic       long_press,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             ready_q, ready_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rpt_q, rpt_d;
  logic             step_q, step_d;
  logic             long_press_q, long_press_d;
  logic [7:0]       press_count_q, press_count_d;

  logic act;
  logic act_q;

  assign act   = (key_in == ACTIVE_LVL);
  assign act_q = (key_q == ACTIVE_LVL);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_d         = key_in;
    ready_d       = 1'b1;
    press_d       = 1'b0;
    release_d     = 1'b0;
    rpt_d         = 1'b0;
    step_d        = 1'b0;
    long_press_d  = long_press_q;
    press_count_d = press_count_q;

    if (!en) begin
      state_d      = IDLE;
      cnt_d        = '0;
      long_press_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d        = '0;
          long_press_d = 1'b0;
          // ready_q masks the first edge after reset, while key_q is still
          // reloading, so a key held through reset is not seen as a new press.
          if (act && !act_q && ready_q) begin
            state_d       = HELD;
            press_d       = 1'b1;
            step_d        = 1'b1;
            press_count_d = press_count_q + 8'd1;
          end
        end
        HELD: begin
          if (!act) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d      = REPEAT;
            cnt_d        = '0;
            rpt_d        = 1'b1;
            step_d       = 1'b1;
            long_press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!act) begin
            state_d      = IDLE;
            release_d    = 1'b1;
            long_press_d = 1'b0;
            cnt_d        = '0;
          end else if (cnt_q == REPEAT_LAST) begin
            cnt_d  = '0;
            rpt_d  = 1'b1;
            step_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d      = IDLE;
          cnt_d        = '0;
          long_press_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_q         <= ~ACTIVE_LVL;
      ready_q       <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      rpt_q         <= 1'b0;
      step_q        <= 1'b0;
      long_press_q  <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      ready_q       <= ready_d;
      press_q       <= press_d;
      release_q     <= release_d;
      rpt_q         <= rpt_d;
      step_q        <= step_d;
      long_press_q  <= long_press_d;
      press_count_q <= press_count_d;
    end
  end

  assign press       = press_q;
  assign key_release = release_q;
  assign rpt         = rpt_q;
  assign step        = step_q;
  assign long_press  = long_press_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_key_repeat.sv
// Directed self-checking bench for key_repeat with HOLD=8, REPEAT=4.
module tb_key_repeat;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       key_in;
  logic       press;
  logic       key_release;
  logic       rpt;
  logic       step;
  logic       long_press;
  logic [7:0] press_count;

  int vectors;
  int miscompares;

  key_repeat #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (8),
    .ACTIVE_LVL   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .key_in     (key_in),
    .press      (press),
    .key_release(key_release),
    .rpt        (rpt),
    .step       (step),
    .long_press (long_press),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, advance one edge, and leave time 1 unit past the edge for sampling.
  task automatic applyStimulus(input logic key, input logic enable);
    key_in = key;
    en     = enable;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkPulses(input string tag, input logic e_press, input logic e_rel,
                             input logic e_rpt, input logic e_long);
    checkOutput({tag, ".press"}, press, e_press);
    checkOutput({tag, ".release"}, key_release, e_rel);
    checkOutput({tag, ".rpt"}, rpt, e_rpt);
    checkOutput({tag, ".step"}, step, e_press | e_rpt);
    checkOutput({tag, ".long"}, long_press, e_long);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    en          = 1'b1;
    key_in      = 1'b0;
    #2;
    checkPulses("reset", 0, 0, 0, 0);
    checkOutput("reset.count", press_count, 0);
    #10;
    rst_n = 1'b1;
    applyStimulus(0, 1);
    applyStimulus(0, 1);

    // Short press: 5 cycles high.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1);
      checkPulses("short", i == 0, 0, 0, 0);
    end
    applyStimulus(0, 1);
    checkPulses("short_drop", 0, 1, 0, 0);
    checkOutput("short.count", press_count, 1);
    applyStimulus(0, 1);
    checkPulses("short_after", 0, 0, 0, 0);

    // Long hold 20 edges; drop lands on REPEAT terminal, release must win.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1);
      checkPulses("long", i == 0, 0, (i == 8) || (i == 12) || (i == 16), i >= 8);
    end
    applyStimulus(0, 1);
    checkPulses("long_drop", 0, 1, 0, 0);
    checkOutput("long.count", press_count, 2);
    applyStimulus(0, 1);
    checkPulses("long_after", 0, 0, 0, 0);

    // Drop exactly when HELD counter is at terminal.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1);
      checkPulses("term", i == 0, 0, 0, 0);
    end
    applyStimulus(0, 1);
    checkPulses("term_drop", 0, 1, 0, 0);
    applyStimulus(0, 1);
    checkPulses("term_after", 0, 0, 0, 0);
    checkOutput("term.count", press_count, 3);

    // Enable dropped during REPEAT, re-raised with key still held.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1);
      checkPulses("en_hold", i == 0, 0, i == 8, i >= 8);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0);
      checkPulses("en_off", 0, 0, 0, 0);
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 1);
      checkPulses("en_back", 0, 0, 0, 0);
    end
    checkOutput("en.count_held", press_count, 4);
    applyStimulus(0, 1);
    checkPulses("en_drop", 0, 0, 0, 0);
    applyStimulus(1, 1);
    checkPulses("en_repress", 1, 0, 0, 0);
    checkOutput("en.count", press_count, 5);
    applyStimulus(0, 1);
    checkPulses("en_release", 0, 1, 0, 0);

    // Reset mid-hold, key stays held through reset release.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1);
    checkOutput("pre_rst.count", press_count, 6);
    rst_n = 1'b0;
    #1;
    checkPulses("rst_mid", 0, 0, 0, 0);
    checkOutput("rst_mid.count", press_count, 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1);
      checkPulses("rst_held", 0, 0, 0, 0);
    end
    applyStimulus(0, 1);
    checkPulses("rst_drop", 0, 0, 0, 0);
    checkOutput("rst.count", press_count, 0);

    // 257 short presses wrap the counter to 1.
    for (int i = 1; i <= 257; i++) begin
      applyStimulus(1, 1);
      if (i == 1 || i == 256 || i == 257) checkOutput("wrap.press", press, 1);
      if (i == 1) checkOutput("wrap.first", press_count, 1);
      if (i == 255) checkOutput("wrap.255", press_count, 255);
      if (i == 256) checkOutput("wrap.zero", press_count, 0);
      applyStimulus(0, 1);
    end
    checkOutput("wrap.final", press_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
